dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-through, no-write-allocate data cache between the RISC-V datapath's memory port and main data memory. The datapath issues word-addressed loads and stores; hits return in the same cycle, and misses and all stores stall the core. Main memory is reached through a simple req/ack handshake. One word per line.

## Interface
- NBITS, 8, data and byte-address width; the CPU word address is NBITS-2 bits.
- NLINES, 8, number of cache lines; power of 2, ≥2, ≤2^(NBITS-2).
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Address  in  [NBITS-1:2]  CPU word address.
- WriteData  in  NBITS  store data.
- MemRead  in  1  load request.
- MemWrite  in  1  store request; wins over MemRead if both are high.
- ReadData  out  NBITS  load data; valid when MemRead=1 and Stall=0.
- Stall  out  1  core must hold Address/WriteData/MemRead/MemWrite stable while high.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 means write, registered.
- mem_addr  out  [NBITS-1:2]  memory word address, registered.
- mem_wdata  out  NBITS  memory write data, registered.
- mem_rdata  in  NBITS  memory read data; sampled when mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse from memory.
- (DCACHE_STATS_EN only) hit_count, miss_count  out  16 each  saturating counters.

## Operation
- Address split:
  - index = Address[$clog2(NLINES)+1:2].
  - tag = Address[NBITS-1:$clog2(NLINES)+2].
- Per-line storage: valid bit, tag, and one data word. hit = valid[index] && tag match.
- FSM states: IDLE, RMISS, WRITE, DONE.
- IDLE:
  - MemWrite: Stall=1. Load mem_req=1, mem_we=1, mem_addr=Address, mem_wdata=WriteData. Go to WRITE.
  - MemRead and hit: ReadData=line data, Stall=0, stay in IDLE.
  - MemRead and miss: Stall=1. Load mem_req=1, mem_we=0, mem_addr=Address. Go to RMISS.
  - Neither: Stall=0, ReadData=0.
- RMISS: hold mem_* stable. On mem_ack:
  - write mem_rdata into line[index] and set valid and tag;
  - latch mem_rdata into a return register;
  - clear mem_req; go to DONE.
- WRITE: hold mem_* stable. On mem_ack:
  - if hit, update line data to WriteData (no-write-allocate: a miss leaves the line untouched);
  - clear mem_req and mem_we; go to DONE.
- DONE: Stall=0 for exactly one cycle; ReadData = return register for a load; go to IDLE.
- mem_req stays high from the cycle after the request is accepted until the cycle mem_ack is sampled; mem_ack while in IDLE or DONE is ignored.
- Reset:
  - all valid bits, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, return register=0, counters=0.
  - A reset mid-miss or mid-write abandons the transfer; the line is not updated.
- Line data and tags are not reset; only valid bits are.

## Timing
- Read hit: 0 wait states; ReadData is combinational from Address.
- Read miss: the request cycle (IDLE) drives Stall=1 and registers mem_req. If mem_ack arrives L cycles after mem_req rises (L≥0, ack in the same cycle counts as L=0), DONE follows one cycle after the ack cycle. The core stalls 2+L cycles.
- Store: same as a read miss, always, regardless of hit.
- Refill timing: the refilled line is visible to a hit in the first IDLE cycle after DONE.
- Back-to-back: a new request in the cycle after DONE is handled by IDLE normally.

## Configuration
- DCACHE_STATS_EN defined:
  - hit_count increments on each IDLE read hit;
  - miss_count increments on each IDLE read miss;
  - both saturate at 16'hFFFF and clear on reset; stores are not counted.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then MemRead Address=6'h05 with memory holding 8'hA5 and ack after 2 cycles -> Stall high for 4 cycles, ReadData=8'hA5 in DONE, mem_addr=6'h05, mem_we=0.
- Repeat the read of 6'h05 -> Stall=0 in the same cycle, ReadData=8'hA5, no mem_req.
- Read 6'h0D (same index 5, different tag) -> miss with refill; then read 6'h05 -> miss again (line evicted).
- Store 8'h3C to 6'h0D (hit), ack with L=0 -> mem_req/mem_we high one cycle, Stall high for 2 cycles; then a read of 6'h0D hits with 8'h3C. Store to the uncached 6'h11 -> memory written, a read of 6'h11 then misses.
- Assert reset while in RMISS before ack -> next cycle mem_req=0, state IDLE; a read of 6'h05 then misses.
- With DCACHE_STATS_EN: the sequence miss, hit, hit, miss -> hit_count=2, miss_count=2.

Source files
------------

// File: rtl/dcache_if.sv
// Memory-side handshake bundle for dcache: request/address/data out, read data and ack back.
interface dcache_if #(
    parameter int NBITS = 8
);
    logic             mem_req;
    logic             mem_we;
    logic [NBITS-1:2] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic [NBITS-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache #(
    parameter int NBITS  = 8,
    parameter int NLINES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:2] Address,
    input  logic [NBITS-1:0] WriteData,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [NBITS-1:0] ReadData,
    output logic             Stall,
    dcache_if.master         mem_bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
`endif
);

    localparam int IDXW = $clog2(NLINES);
    localparam int TAGW = NBITS - 2 - IDXW;
    localparam int TAGS = (TAGW > 0) ? TAGW : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RMISS = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [NLINES-1:0] r_valid;
    logic [TAGS-1:0]   r_tag  [NLINES];
    logic [NBITS-1:0]  r_data [NLINES];

    logic             r_mem_req;
    logic             r_mem_we;
    logic [NBITS-1:2] r_mem_addr;
    logic [NBITS-1:0] r_mem_wdata;
    logic [NBITS-1:0] r_ret;

    logic             w_mem_req;
    logic             w_mem_we;
    logic [NBITS-1:2] w_mem_addr;
    logic [NBITS-1:0] w_mem_wdata;
    logic             w_refill;
    logic             w_wr_update;

    logic [IDXW-1:0]  w_idx;
    logic [IDXW-1:0]  w_midx;
    logic [TAGS-1:0]  w_tag;
    logic [TAGS-1:0]  w_mtag;
    logic             w_hit;
    logic             w_mhit;

    assign w_idx  = Address[IDXW+1:2];
    assign w_midx = r_mem_addr[IDXW+1:2];

    generate
        if (TAGW > 0) begin : g_tag
            assign w_tag  = Address[NBITS-1:IDXW+2];
            assign w_mtag = r_mem_addr[NBITS-1:IDXW+2];
        end else begin : g_notag
            assign w_tag  = '0;
            assign w_mtag = '0;
        end
    endgenerate

    // Refill and store-update decisions use the latched request address, which
    // the core holds equal to Address while stalled.
    assign w_hit  = r_valid[w_idx]  && (r_tag[w_idx]  == w_tag);
    assign w_mhit = r_valid[w_midx] && (r_tag[w_midx] == w_mtag);

    assign mem_bus.mem_req   = r_mem_req;
    assign mem_bus.mem_we    = r_mem_we;
    assign mem_bus.mem_addr  = r_mem_addr;
    assign mem_bus.mem_wdata = r_mem_wdata;

    // State register and registered memory-port request fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ret       <= '0;
            r_valid     <= '0;
        end else begin
            r_state     <= w_next_state;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            if (w_refill) begin
                r_ret           <= mem_bus.mem_rdata;
                r_valid[w_midx] <= 1'b1;
            end
        end
    end

    // Line tag/data storage; not reset, and a reset cycle suppresses any update.
    always_ff @(posedge clock) begin
        if (!reset && w_refill) begin
            r_tag[w_midx]  <= w_mtag;
            r_data[w_midx] <= mem_bus.mem_rdata;
        end else if (!reset && w_wr_update) begin
            r_data[w_midx] <= r_mem_wdata;
        end
    end

    // Next-state, stall/read-data outputs and next memory request fields.
    always_comb begin
        w_next_state = r_state;
        Stall        = 1'b0;
        ReadData     = '0;
        w_mem_req    = r_mem_req;
        w_mem_we     = r_mem_we;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_refill     = 1'b0;
        w_wr_update  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (MemWrite) begin
                    Stall        = 1'b1;
                    w_mem_req    = 1'b1;
                    w_mem_we     = 1'b1;
                    w_mem_addr   = Address;
                    w_mem_wdata  = WriteData;
                    w_next_state = ST_WRITE;
                end else if (MemRead && w_hit) begin
                    ReadData = r_data[w_idx];
                end else if (MemRead) begin
                    Stall        = 1'b1;
                    w_mem_req    = 1'b1;
                    w_mem_we     = 1'b0;
                    w_mem_addr   = Address;
                    w_next_state = ST_RMISS;
                end else begin
                    Stall = 1'b0;
                end
            end
            ST_RMISS: begin
                Stall = 1'b1;
                if (mem_bus.mem_ack) begin
                    w_refill     = 1'b1;
                    w_mem_req    = 1'b0;
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RMISS;
                end
            end
            ST_WRITE: begin
                Stall = 1'b1;
                if (mem_bus.mem_ack) begin
                    w_wr_update  = w_mhit;
                    w_mem_req    = 1'b0;
                    w_mem_we     = 1'b0;
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_DONE: begin
                if (MemRead && !MemWrite) begin
                    ReadData = r_ret;
                end else begin
                    ReadData = '0;
                end
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic        w_rd_hit;
    logic        w_rd_miss;
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    assign w_rd_hit   = (r_state == ST_IDLE) && MemRead && !MemWrite && w_hit;
    assign w_rd_miss  = (r_state == ST_IDLE) && MemRead && !MemWrite && !w_hit;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Saturating read hit/miss counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_count  <= 16'h0000;
            r_miss_count <= 16'h0000;
        end else begin
            if (w_rd_hit && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'h0001;
            end
            if (w_rd_miss && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache with a small handshake memory model.
module tb_dcache;

    logic       clock;
    logic       reset;
    logic [7:2] Address;
    logic [7:0] WriteData;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] ReadData;
    logic       Stall;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dcache_if #(.NBITS(8)) bus ();

    dcache #(.NBITS(8), .NLINES(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .mem_bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [7:0] tbmem [64];

    int         t_stall;
    int         t_req_n;
    logic [7:0] t_rd;
    logic       t_saw;
    logic [7:2] t_addr;
    logic       t_we;
    logic       t_ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; performs one access and serves memory with ack latency lat.
    task automatic access(input logic wr, input logic [7:2] addr, input logic [7:0] wd, input int lat);
        int k;
        k       = 0;
        t_stall = 0;
        t_req_n = 0;
        t_rd    = 8'h00;
        t_saw   = 1'b0;
        t_addr  = 6'h00;
        t_we    = 1'b0;
        t_ok    = 1'b0;
        Address   = addr;
        WriteData = wd;
        MemWrite  = wr;
        MemRead   = ~wr;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!Stall) begin
                t_rd = ReadData;
                t_ok = 1'b1;
                break;
            end
            t_stall++;
            if (bus.mem_req) begin
                if (!t_saw) begin
                    t_saw  = 1'b1;
                    t_addr = bus.mem_addr;
                    t_we   = bus.mem_we;
                end
                t_req_n++;
                if (k == lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = tbmem[bus.mem_addr];
                    if (bus.mem_we) tbmem[bus.mem_addr] = bus.mem_wdata;
                end
                k++;
            end
            @(negedge clock);
            bus.mem_ack = 1'b0;
        end
        check("access_completes", {31'd0, t_ok}, 32'd1);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tbmem[i] = 8'(i * 7 + 3);
        tbmem[6'h05] = 8'hA5;
        tbmem[6'h0D] = 8'h5A;
        tbmem[6'h11] = 8'h77;
        Address       = 6'h00;
        WriteData     = 8'h00;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        @(negedge clock);
        do_reset();
        #1;
        check("rst_stall",     {31'd0, Stall},       32'd0);
        check("rst_readdata",  {24'd0, ReadData},    32'd0);
        check("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_we",    {31'd0, bus.mem_we},  32'd0);
        check("rst_mem_addr",  {26'd0, bus.mem_addr},  32'd0);
        check("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        @(negedge clock);

        // Cold miss on 0x05, ack two cycles after request rises.
        access(1'b0, 6'h05, 8'h00, 2);
        check("miss05_stall", t_stall, 32'd4);
        check("miss05_rd",    {24'd0, t_rd}, 32'hA5);
        check("miss05_addr",  {26'd0, t_addr}, 32'h05);
        check("miss05_we",    {31'd0, t_we}, 32'd0);
        check("miss05_req_n", t_req_n, 32'd3);

        access(1'b0, 6'h05, 8'h00, 0);
        check("hit05_stall", t_stall, 32'd0);
        check("hit05_rd",    {24'd0, t_rd}, 32'hA5);
        check("hit05_noreq", {31'd0, t_saw}, 32'd0);

        // Conflicting tag on the same index evicts 0x05.
        access(1'b0, 6'h0D, 8'h00, 1);
        check("miss0D_stall", t_stall, 32'd3);
        check("miss0D_rd",    {24'd0, t_rd}, 32'h5A);
        access(1'b0, 6'h05, 8'h00, 0);
        check("evict05_stall", t_stall, 32'd2);
        check("evict05_rd",    {24'd0, t_rd}, 32'hA5);
        access(1'b0, 6'h0D, 8'h00, 0);
        check("refill0D_stall", t_stall, 32'd2);

        // Store hit with zero-latency ack.
        access(1'b1, 6'h0D, 8'h3C, 0);
        check("st0D_stall", t_stall, 32'd2);
        check("st0D_req_n", t_req_n, 32'd1);
        check("st0D_we",    {31'd0, t_we}, 32'd1);
        check("st0D_addr",  {26'd0, t_addr}, 32'h0D);
        check("st0D_rd0",   {24'd0, t_rd}, 32'd0);
        check("st0D_mem",   {24'd0, tbmem[6'h0D]}, 32'h3C);
        access(1'b0, 6'h0D, 8'h00, 0);
        check("rd0D_stall", t_stall, 32'd0);
        check("rd0D_rd",    {24'd0, t_rd}, 32'h3C);

        // Store to a different tag on a cached index must leave the line alone.
        access(1'b1, 6'h05, 8'h44, 0);
        check("st05_mem", {24'd0, tbmem[6'h05]}, 32'h44);
        access(1'b0, 6'h0D, 8'h00, 0);
        check("keep0D_stall", t_stall, 32'd0);
        check("keep0D_rd",    {24'd0, t_rd}, 32'h3C);

        // Store to an uncached line: written through, not allocated.
        access(1'b1, 6'h11, 8'h99, 1);
        check("st11_stall", t_stall, 32'd3);
        check("st11_mem",   {24'd0, tbmem[6'h11]}, 32'h99);
        access(1'b0, 6'h11, 8'h00, 0);
        check("rd11_stall", t_stall, 32'd2);
        check("rd11_rd",    {24'd0, t_rd}, 32'h99);

        // Reset while a read miss is outstanding.
        Address = 6'h05;
        MemRead = 1'b1;
        @(negedge clock);
        #1;
        check("rmiss_req", {31'd0, bus.mem_req}, 32'd1);
        reset   = 1'b1;
        MemRead = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rstmid_req",   {31'd0, bus.mem_req}, 32'd0);
        check("rstmid_stall", {31'd0, Stall}, 32'd0);
        @(negedge clock);
        access(1'b0, 6'h05, 8'h00, 0);
        check("post_rst_stall", t_stall, 32'd2);
        check("post_rst_rd",    {24'd0, t_rd}, 32'h44);

`ifdef DCACHE_STATS_EN
        do_reset();
        access(1'b0, 6'h05, 8'h00, 0);
        access(1'b0, 6'h05, 8'h00, 0);
        access(1'b0, 6'h05, 8'h00, 0);
        access(1'b0, 6'h0D, 8'h00, 0);
        check("hit_count",  {16'd0, hit_count},  32'd2);
        check("miss_count", {16'd0, miss_count}, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
